// File: rtl/ibex_rf_wb_pkg.sv
// Shared types and helpers for the register-file write-back arbiter.
// Optional forwarding is enabled with the IBEX_RF_WB_FWD_EN macro (see ibex_rf_wb_arbiter).
package ibex_rf_wb_pkg;

  localparam int unsigned WbDataWidth  = 32;
  localparam int unsigned RegAddrWidth = 5;

  typedef struct packed {
    logic [RegAddrWidth-1:0] waddr;
    logic [WbDataWidth-1:0]  wdata;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_LOAD,
    WB_EXFIFO,
    WB_EXDIRECT
  } wb_src_e;

  // RV32E only has 16 registers, so bit 4 never takes part in a write or a compare.
  function automatic logic [RegAddrWidth-1:0] rf_addr_mask(input logic [RegAddrWidth-1:0] addr,
                                                           input logic                    rv32e);
    return rv32e ? {1'b0, addr[RegAddrWidth-2:0]} : addr;
  endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// Shift-register FIFO of register addresses plus data; entry 0 is the oldest.
// Every entry is visible so the arbiter can compare addresses for hazards and forwarding.
module ibex_rf_wb_fifo
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned Depth     = 2,
  parameter int unsigned DataWidth = 32
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       push_i,
  input  logic [RegAddrWidth-1:0]                    waddr_i,
  input  logic [DataWidth-1:0]                       wdata_i,
  input  logic                                       pop_i,
  output logic                                       full_o,
  output logic                                       empty_o,
  output logic [Depth-1:0]                           valid_o,
  output logic [Depth-1:0][RegAddrWidth-1:0]         waddr_o,
  output logic [Depth-1:0][DataWidth-1:0]            wdata_o
);

  logic [Depth-1:0]                   valid_d, valid_q;
  logic [Depth-1:0][RegAddrWidth-1:0] waddr_d, waddr_q;
  logic [Depth-1:0][DataWidth-1:0]    wdata_d, wdata_q;
  logic                               placed;

  always_comb begin
    valid_d = valid_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    placed  = 1'b0;
    if (pop_i && valid_q[0]) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        valid_d[i] = valid_q[i+1];
        waddr_d[i] = waddr_q[i+1];
        wdata_d[i] = wdata_q[i+1];
      end
      valid_d[Depth-1] = 1'b0;
    end
    // Push lands in the first free slot after any pop, so push+pop on a full FIFO works.
    if (push_i) begin
      for (int i = 0; i < int'(Depth); i++) begin
        if (!placed && !valid_d[i]) begin
          valid_d[i] = 1'b1;
          waddr_d[i] = waddr_i;
          wdata_d[i] = wdata_i;
          placed     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign full_o  = &valid_q;
  assign empty_o = ~valid_q[0];
  assign valid_o = valid_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Sole driver of the register-file write port: merges EX results and load responses.
// Define IBEX_RF_WB_FWD_EN to add operand forwarding from buffered/in-flight writes.
module ibex_rf_wb_arbiter
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned DataWidth   = 32,
  parameter bit          RV32E       = 1'b0,
  parameter int unsigned ExFifoDepth = 2,
  parameter int unsigned MaxLoads    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_we_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 load_issue_i,
  input  logic [4:0]           load_waddr_i,
  output logic                 load_issue_ready_o,
  input  logic                 lsu_rvalid_i,
  input  logic                 lsu_err_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic [4:0]           rs_a_i,
  input  logic [4:0]           rs_b_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
`ifdef IBEX_RF_WB_FWD_EN
  ,
  output logic [DataWidth-1:0] rdata_fwd_a_o,
  output logic [DataWidth-1:0] rdata_fwd_b_o,
  output logic                 fwd_a_o,
  output logic                 fwd_b_o
`endif
);

  logic [4:0] ex_waddr_m, load_waddr_m, rs_a_m, rs_b_m;

  logic                                exf_push, exf_pop, exf_full, exf_empty;
  logic [ExFifoDepth-1:0]              exf_valid;
  logic [ExFifoDepth-1:0][4:0]         exf_waddr;
  logic [ExFifoDepth-1:0][DataWidth-1:0] exf_wdata;

  logic                        ld_push, ld_pop, ld_full, ld_empty;
  logic [MaxLoads-1:0]         ld_valid;
  logic [MaxLoads-1:0][4:0]    ld_waddr;
  logic [MaxLoads-1:0][0:0]    ld_wdata_unused;

  logic          load_wr, ex_waw, ex_acc, ex_direct;
  wb_src_e       src;
  logic [4:0]    sel_waddr;
  logic [DataWidth-1:0] sel_wdata;

  logic                 rf_we_d, rf_we_q;
  logic [4:0]           rf_waddr_d, rf_waddr_q;
  logic [DataWidth-1:0] rf_wdata_d, rf_wdata_q;
  logic                 prev_we_d, prev_we_q;
  logic [4:0]           prev_waddr_d, prev_waddr_q;

  assign ex_waddr_m   = rf_addr_mask(ex_waddr_i, RV32E);
  assign load_waddr_m = rf_addr_mask(load_waddr_i, RV32E);
  assign rs_a_m       = rf_addr_mask(rs_a_i, RV32E);
  assign rs_b_m       = rf_addr_mask(rs_b_i, RV32E);

  function automatic logic ld_hit(input logic [4:0]               a,
                                  input logic [MaxLoads-1:0]      v,
                                  input logic [MaxLoads-1:0][4:0] ad);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(MaxLoads); i++) begin
      if (v[i] && ad[i] == a) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic exf_hit(input logic [4:0]                  a,
                                   input logic [ExFifoDepth-1:0]      v,
                                   input logic [ExFifoDepth-1:0][4:0] ad);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(ExFifoDepth); i++) begin
      if (v[i] && ad[i] == a) hit = 1'b1;
    end
    return hit;
  endfunction

  // A load response that arrives with nothing outstanding is discarded.
  assign ld_pop  = lsu_rvalid_i && !ld_empty;
  assign load_wr = ld_pop && !lsu_err_i;
  assign ld_push = load_issue_i && (!ld_full || ld_pop);
  assign load_issue_ready_o = !ld_full;

  // EX must not overtake an older load to the same register.
  assign ex_waw     = (ex_waddr_m != 5'd0) && ld_hit(ex_waddr_m, ld_valid, ld_waddr);
  assign exf_pop    = !load_wr && !exf_empty;
  assign ex_ready_o = !ex_waw && (!exf_full || exf_pop);
  assign ex_acc     = ex_we_i && ex_ready_o;
  assign ex_direct  = ex_acc && !load_wr && exf_empty;
  assign exf_push   = ex_acc && !ex_direct;

  ibex_rf_wb_fifo #(
    .Depth    (ExFifoDepth),
    .DataWidth(DataWidth)
  ) u_ex_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (exf_push),
    .waddr_i(ex_waddr_m),
    .wdata_i(ex_wdata_i),
    .pop_i  (exf_pop),
    .full_o (exf_full),
    .empty_o(exf_empty),
    .valid_o(exf_valid),
    .waddr_o(exf_waddr),
    .wdata_o(exf_wdata)
  );

  ibex_rf_wb_fifo #(
    .Depth    (MaxLoads),
    .DataWidth(1)
  ) u_load_tracker (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (ld_push),
    .waddr_i(load_waddr_m),
    .wdata_i(1'b0),
    .pop_i  (ld_pop),
    .full_o (ld_full),
    .empty_o(ld_empty),
    .valid_o(ld_valid),
    .waddr_o(ld_waddr),
    .wdata_o(ld_wdata_unused)
  );

  always_comb begin
    src       = WB_NONE;
    sel_waddr = '0;
    sel_wdata = '0;
    if (load_wr) begin
      src       = WB_LOAD;
      sel_waddr = ld_waddr[0];
      sel_wdata = lsu_rdata_i;
    end else if (exf_pop) begin
      src       = WB_EXFIFO;
      sel_waddr = exf_waddr[0];
      sel_wdata = exf_wdata[0];
    end else if (ex_direct) begin
      src       = WB_EXDIRECT;
      sel_waddr = ex_waddr_m;
      sel_wdata = ex_wdata_i;
    end
  end

  // x0 writes retire through the selection above but never reach the RF.
  always_comb begin
    rf_we_d      = (src != WB_NONE) && (sel_waddr != 5'd0);
    rf_waddr_d   = rf_we_d ? sel_waddr : 5'd0;
    rf_wdata_d   = rf_we_d ? sel_wdata : '0;
    prev_we_d    = rf_we_q;
    prev_waddr_d = rf_waddr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      prev_we_q    <= 1'b0;
      prev_waddr_q <= '0;
    end else begin
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      prev_we_q    <= prev_we_d;
      prev_waddr_q <= prev_waddr_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

`ifdef IBEX_RF_WB_FWD_EN
  logic [DataWidth-1:0] prev_wdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_wdata_q <= '0;
    else         prev_wdata_q <= rf_wdata_q;
  end

  // Later assignments override earlier ones, so the youngest matching write wins.
  function automatic logic [DataWidth:0] fwd_lookup(input logic [4:0] a);
    logic [DataWidth:0] r;
    r = '0;
    if (prev_we_q && prev_waddr_q == a) r = {1'b1, prev_wdata_q};
    if (rf_we_q && rf_waddr_q == a)     r = {1'b1, rf_wdata_q};
    for (int i = 0; i < int'(ExFifoDepth); i++) begin
      if (exf_valid[i] && exf_waddr[i] == a) r = {1'b1, exf_wdata[i]};
    end
    if (a == 5'd0) r = '0;
    return r;
  endfunction

  always_comb begin
    {fwd_a_o, rdata_fwd_a_o} = fwd_lookup(rs_a_m);
    {fwd_b_o, rdata_fwd_b_o} = fwd_lookup(rs_b_m);
    hazard_a_o = (rs_a_m != 5'd0) && ld_hit(rs_a_m, ld_valid, ld_waddr);
    hazard_b_o = (rs_b_m != 5'd0) && ld_hit(rs_b_m, ld_valid, ld_waddr);
  end
`else
  always_comb begin
    hazard_a_o = (rs_a_m != 5'd0) &&
                 (exf_hit(rs_a_m, exf_valid, exf_waddr) ||
                  (rf_we_q && rf_waddr_q == rs_a_m) ||
                  (prev_we_q && prev_waddr_q == rs_a_m) ||
                  ld_hit(rs_a_m, ld_valid, ld_waddr));
    hazard_b_o = (rs_b_m != 5'd0) &&
                 (exf_hit(rs_b_m, exf_valid, exf_waddr) ||
                  (rf_we_q && rf_waddr_q == rs_b_m) ||
                  (prev_we_q && prev_waddr_q == rs_b_m) ||
                  ld_hit(rs_b_m, ld_valid, ld_waddr));
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni) assert (!(lsu_rvalid_i && ld_empty));
  end
`endif

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Directed bench for ibex_rf_wb_arbiter in its default (non-forwarding) build.
module tb_ibex_rf_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        ex_we_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        ex_ready_o;
  logic        load_issue_i;
  logic [4:0]  load_waddr_i;
  logic        load_issue_ready_o;
  logic        lsu_rvalid_i;
  logic        lsu_err_i;
  logic [31:0] lsu_rdata_i;
  logic [4:0]  rs_a_i, rs_b_i;
  logic        hazard_a_o, hazard_b_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  int errors = 0;
  int checks = 0;

  logic [4:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  ibex_rf_wb_arbiter dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .ex_we_i           (ex_we_i),
    .ex_waddr_i        (ex_waddr_i),
    .ex_wdata_i        (ex_wdata_i),
    .ex_ready_o        (ex_ready_o),
    .load_issue_i      (load_issue_i),
    .load_waddr_i      (load_waddr_i),
    .load_issue_ready_o(load_issue_ready_o),
    .lsu_rvalid_i      (lsu_rvalid_i),
    .lsu_err_i         (lsu_err_i),
    .lsu_rdata_i       (lsu_rdata_i),
    .rs_a_i            (rs_a_i),
    .rs_b_i            (rs_b_i),
    .hazard_a_o        (hazard_a_o),
    .hazard_b_o        (hazard_b_o),
    .rf_we_o           (rf_we_o),
    .rf_waddr_o        (rf_waddr_o),
    .rf_wdata_o        (rf_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every RF write, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && rf_we_o === 1'b1) begin
      wq_addr.push_back(rf_waddr_o);
      wq_data.push_back(rf_wdata_o);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ex_we_i = 1'b0; ex_waddr_i = '0; ex_wdata_i = '0;
    load_issue_i = 1'b0; load_waddr_i = '0;
    lsu_rvalid_i = 1'b0; lsu_err_i = 1'b0; lsu_rdata_i = '0;
  endtask

  task automatic test_reset();
    idle();
    rs_a_i = 5'd5; rs_b_i = 5'd7;
    rst_ni = 1'b0;
    repeat (2) cyc();
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", rf_we_o); end
    checks++; if (rf_waddr_o !== 5'd0) begin errors++; $display("FAIL reset_waddr got=%0d want=0", rf_waddr_o); end
    checks++; if (rf_wdata_o !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h want=0", rf_wdata_o); end
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ex_ready got=%b want=1", ex_ready_o); end
    checks++; if (load_issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ld_ready got=%b want=1", load_issue_ready_o); end
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b00) begin errors++; $display("FAIL reset_hazard got=%b want=00", {hazard_a_o, hazard_b_o}); end
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_ex_write();
    wq_addr.delete(); wq_data.delete();
    rs_a_i = 5'd5; rs_b_i = 5'd0;
    ex_we_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'hDEADBEEF;
    #1;
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL exw_ready got=%b want=1", ex_ready_o); end
    cyc(); idle();
    #1;
    checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL exw_we got=%b want=1", rf_we_o); end
    checks++; if (rf_waddr_o !== 5'd5) begin errors++; $display("FAIL exw_waddr got=%0d want=5", rf_waddr_o); end
    checks++; if (rf_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL exw_wdata got=%h want=deadbeef", rf_wdata_o); end
    checks++; if (hazard_a_o !== 1'b1) begin errors++; $display("FAIL exw_haz_out got=%b want=1", hazard_a_o); end
    cyc();
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL exw_we_once got=%b want=0", rf_we_o); end
    checks++; if (hazard_a_o !== 1'b1) begin errors++; $display("FAIL exw_haz_prev got=%b want=1", hazard_a_o); end
    cyc();
    checks++; if (hazard_a_o !== 1'b0) begin errors++; $display("FAIL exw_haz_clear got=%b want=0", hazard_a_o); end
    checks++; if (wq_addr.size() !== 1) begin errors++; $display("FAIL exw_count got=%0d want=1", wq_addr.size()); end
  endtask

  task automatic test_load_collide();
    wq_addr.delete(); wq_data.delete();
    rs_a_i = 5'd3; rs_b_i = 5'd7;
    load_issue_i = 1'b1; load_waddr_i = 5'd7;
    cyc(); idle();
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h1234;
    ex_we_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'h55;
    #1;
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL col_ready got=%b want=1", ex_ready_o); end
    checks++; if (hazard_b_o !== 1'b1) begin errors++; $display("FAIL col_haz_load got=%b want=1", hazard_b_o); end
    cyc(); idle();
    #1;
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd7, 32'h1234}) begin
      errors++; $display("FAIL col_first got=%b/%0d/%h want=1/7/1234", rf_we_o, rf_waddr_o, rf_wdata_o); end
    checks++; if (hazard_a_o !== 1'b1) begin errors++; $display("FAIL col_haz_fifo got=%b want=1", hazard_a_o); end
    cyc();
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd3, 32'h55}) begin
      errors++; $display("FAIL col_second got=%b/%0d/%h want=1/3/55", rf_we_o, rf_waddr_o, rf_wdata_o); end
    cyc();
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL col_idle got=%b want=0", rf_we_o); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ea [6];
    logic [31:0] ed [6];
    ea = '{5'd10, 5'd11, 5'd12, 5'd20, 5'd21, 5'd22};
    ed = '{32'hA10, 32'hA11, 32'hA12, 32'h20, 32'h21, 32'h22};
    wq_addr.delete(); wq_data.delete();
    rs_a_i = 5'd0; rs_b_i = 5'd0;
    load_issue_i = 1'b1; load_waddr_i = 5'd10;
    cyc(); load_waddr_i = 5'd11;
    cyc(); idle();
    #1;
    checks++; if (load_issue_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_ld_full got=%b want=0", load_issue_ready_o); end
    load_issue_i = 1'b1; load_waddr_i = 5'd12;
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hA10;
    ex_we_i = 1'b1; ex_waddr_i = 5'd20; ex_wdata_i = 32'h20;
    #1;
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got=%b want=1", ex_ready_o); end
    cyc(); load_issue_i = 1'b0;
    lsu_rdata_i = 32'hA11; ex_waddr_i = 5'd21; ex_wdata_i = 32'h21;
    #1;
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got=%b want=1", ex_ready_o); end
    cyc();
    lsu_rdata_i = 32'hA12; ex_waddr_i = 5'd22; ex_wdata_i = 32'h22;
    #1;
    checks++; if (ex_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_full_stall got=%b want=0", ex_ready_o); end
    cyc();
    lsu_rvalid_i = 1'b0; lsu_rdata_i = '0;
    #1;
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_pop_ready got=%b want=1", ex_ready_o); end
    cyc(); idle();
    repeat (5) cyc();
    checks++; if (wq_addr.size() !== 6) begin errors++; $display("FAIL b2b_count got=%0d want=6", wq_addr.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < wq_addr.size()) begin
        checks++;
        if ({wq_addr[i], wq_data[i]} !== {ea[i], ed[i]}) begin
          errors++; $display("FAIL b2b_write%0d got=%0d/%h want=%0d/%h", i, wq_addr[i], wq_data[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_waw();
    wq_addr.delete(); wq_data.delete();
    load_issue_i = 1'b1; load_waddr_i = 5'd9;
    cyc(); idle();
    ex_we_i = 1'b1; ex_waddr_i = 5'd9; ex_wdata_i = 32'hAAAA;
    #1;
    checks++; if (ex_ready_o !== 1'b0) begin errors++; $display("FAIL waw_stall0 got=%b want=0", ex_ready_o); end
    cyc();
    checks++; if (ex_ready_o !== 1'b0) begin errors++; $display("FAIL waw_stall1 got=%b want=0", ex_ready_o); end
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h9999;
    #1;
    checks++; if (ex_ready_o !== 1'b0) begin errors++; $display("FAIL waw_stall_rsp got=%b want=0", ex_ready_o); end
    cyc();
    lsu_rvalid_i = 1'b0; lsu_rdata_i = '0;
    #1;
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL waw_release got=%b want=1", ex_ready_o); end
    cyc(); idle();
    repeat (3) cyc();
    checks++; if (wq_addr.size() !== 2) begin errors++; $display("FAIL waw_count got=%0d want=2", wq_addr.size()); end
    if (wq_addr.size() == 2) begin
      checks++; if ({wq_addr[0], wq_data[0]} !== {5'd9, 32'h9999}) begin
        errors++; $display("FAIL waw_first got=%0d/%h want=9/9999", wq_addr[0], wq_data[0]); end
      checks++; if ({wq_addr[1], wq_data[1]} !== {5'd9, 32'hAAAA}) begin
        errors++; $display("FAIL waw_second got=%0d/%h want=9/aaaa", wq_addr[1], wq_data[1]); end
    end
  endtask

  task automatic test_x0_and_err();
    wq_addr.delete(); wq_data.delete();
    rs_a_i = 5'd6; rs_b_i = 5'd0;
    ex_we_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hFF;
    #1;
    checks++; if (ex_ready_o !== 1'b1) begin errors++; $display("FAIL x0_ready got=%b want=1", ex_ready_o); end
    cyc(); idle();
    #1;
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL x0_no_we got=%b want=0", rf_we_o); end
    load_issue_i = 1'b1; load_waddr_i = 5'd6;
    cyc(); idle();
    #1;
    checks++; if (hazard_a_o !== 1'b1) begin errors++; $display("FAIL err_haz_pending got=%b want=1", hazard_a_o); end
    lsu_rvalid_i = 1'b1; lsu_err_i = 1'b1; lsu_rdata_i = 32'hBAD;
    #1;
    checks++; if (hazard_a_o !== 1'b1) begin errors++; $display("FAIL err_haz_rsp got=%b want=1", hazard_a_o); end
    cyc(); idle();
    #1;
    checks++; if (hazard_a_o !== 1'b0) begin errors++; $display("FAIL err_haz_clear got=%b want=0", hazard_a_o); end
    repeat (2) cyc();
    checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL err_no_write got=%0d want=0", wq_addr.size()); end
  endtask

  task automatic test_mid_reset();
    rs_a_i = 5'd17; rs_b_i = 5'd16;
    load_issue_i = 1'b1; load_waddr_i = 5'd14;
    cyc(); load_waddr_i = 5'd15;
    cyc(); idle();
    load_issue_i = 1'b1; load_waddr_i = 5'd17;
    lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hE14;
    ex_we_i = 1'b1; ex_waddr_i = 5'd16; ex_wdata_i = 32'h16;
    cyc();
    load_issue_i = 1'b0;
    lsu_rdata_i = 32'hE15; ex_waddr_i = 5'd18; ex_wdata_i = 32'h18;
    cyc(); idle();
    #1;
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b11) begin errors++; $display("FAIL mrst_pre_haz got=%b want=11", {hazard_a_o, hazard_b_o}); end
    rst_ni = 1'b0;
    wq_addr.delete(); wq_data.delete();
    #1;
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== 38'd0) begin
      errors++; $display("FAIL mrst_out got=%b/%0d/%h want=0/0/0", rf_we_o, rf_waddr_o, rf_wdata_o); end
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b00) begin errors++; $display("FAIL mrst_haz got=%b want=00", {hazard_a_o, hazard_b_o}); end
    checks++; if ({ex_ready_o, load_issue_ready_o} !== 2'b11) begin
      errors++; $display("FAIL mrst_ready got=%b want=11", {ex_ready_o, load_issue_ready_o}); end
    repeat (2) cyc();
    rst_ni = 1'b1;
    repeat (5) cyc();
    checks++; if (wq_addr.size() !== 0) begin errors++; $display("FAIL mrst_no_write got=%0d want=0", wq_addr.size()); end
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b00) begin errors++; $display("FAIL mrst_haz_after got=%b want=00", {hazard_a_o, hazard_b_o}); end
  endtask

  initial begin
    test_reset();
    test_ex_write();
    test_load_collide();
    test_back_to_back();
    test_waw();
    test_x0_and_err();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_rf_wb_arbiter.md
Name: ibex_rf_wb_arbiter

Overview:
- Write-back arbiter sitting directly upstream of the latch-based register file; sole driver of its single write port (we/waddr/wdata).
- Merges ALU/CSR/mult results from EX with load responses from the LSU, buffering EX writes when a load response collides.
- Tracks outstanding load destinations and pending writes; tells ID which source operands are not yet valid in the RF.

Parameters:
- DataWidth, 32, width of the write data path; must match the register file.
- RV32E, 0, 1 selects 16 architectural registers; only waddr[3:0] is significant and hazard compares use 4 bits.
- ExFifoDepth, 2, entries in the EX write buffer (≥1).
- MaxLoads, 2, maximum outstanding loads tracked (≥1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- ex_we_i  in  1  EX result valid, request to write
- ex_waddr_i  in  5  EX destination register
- ex_wdata_i  in  DataWidth  EX result
- ex_ready_o  out  1  EX write accepted this cycle when ex_we_i & ex_ready_o
- load_issue_i  in  1  LSU accepted a load; push destination
- load_waddr_i  in  5  destination of the issued load
- load_issue_ready_o  out  1  load tracker not full
- lsu_rvalid_i  in  1  load response valid (in issue order)
- lsu_err_i  in  1  load response is a bus error; retire without write
- lsu_rdata_i  in  DataWidth  load data
- rs_a_i  in  5  ID source operand A address
- rs_b_i  in  5  ID source operand B address
- hazard_a_o  out  1  operand A pending, ID must stall
- hazard_b_o  out  1  operand B pending, ID must stall
- rf_we_o  out  1  register file write enable
- rf_waddr_o  out  5  register file write address
- rf_wdata_o  out  DataWidth  register file write data

Behaviour:
- Reset: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, EX FIFO empty, load tracker empty, ex_ready_o=1, load_issue_ready_o=1, hazards=0.
- Output stage is registered. A write selected in cycle N appears on rf_* in cycle N+1 for exactly one cycle. rf_we_o=0 in any cycle with no selected write.
- Selection priority per cycle:
  - load response (rvalid & !err) first;
  - otherwise the EX FIFO head;
  - otherwise a direct EX write, which bypasses the FIFO only if the FIFO is empty.
- EX write with a colliding load, or with FIFO non-empty, is pushed into the FIFO. ex_ready_o=0 when the FIFO is full and no pop occurs this cycle.
- WAW ordering: ex_ready_o=0 while ex_waddr_i matches any outstanding load destination. EX write is held until that load retires.
- Writes to x0 are accepted and retired but never assert rf_we_o.
- Load tracker:
  - in-order FIFO of MaxLoads addresses; pushed on load_issue_i, popped on lsu_rvalid_i;
  - issue and response in the same cycle are both legal (push and pop together);
  - a response with the tracker empty is dropped (assertion fires);
  - on lsu_err_i the entry is popped and no write occurs.
- Hazards (combinational): hazard_x_o=1 iff rs_x_i≠0 and it matches any of:
  - a valid EX FIFO entry;
  - the output stage while rf_we_o=1;
  - the registered-data cycle following it (RF latch transparent one cycle later);
  - any outstanding load.
- Reset mid-operation: all buffered and outstanding state is discarded; no write is issued after reset deasserts.

Optional Feature:
- Macro IBEX_RF_WB_FWD_EN.
- Defined: adds rdata_fwd_a_o/rdata_fwd_b_o (DataWidth) and fwd_a_o/fwd_b_o. Operands matching a buffered EX entry or the output stage are forwarded (youngest match wins) with hazard=0. Hazard is then asserted only for outstanding-load matches.
- Undefined: no forwarding ports; hazard rules as above.

Decomposition:
- Package ibex_rf_wb_pkg: wb_entry_t {logic [4:0] waddr; logic [DataWidth-1:0] wdata}, wb_src_e {WB_NONE, WB_LOAD, WB_EXFIFO, WB_EXDIRECT}.
- One sub-module ibex_rf_wb_fifo (parameterised depth/width, push/pop/full/empty, plus per-entry address visibility for hazard compare). Instanced twice: EX buffer and load tracker (data unused).

Test Plan:
- EX write x5=0xDEADBEEF, idle LSU -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF; hazard_a_o=1 for rs_a_i=5 during that cycle and the following one.
- Issue load to x7; same cycle as rvalid(0x1234) send EX write x3=0x55 -> cycle+1 writes x7=0x1234, cycle+2 writes x3=0x55.
- Three back-to-back EX writes colliding with three load responses -> ex_ready_o drops once the FIFO (depth 2) is full; all six writes occur, none lost, EX writes in order.
- Load to x9 outstanding, EX write x9 -> ex_ready_o=0 until rvalid; RF sees x9=load data then x9=EX data.
- EX write x0=0xFF -> ex_ready_o=1, rf_we_o stays 0; load with lsu_err_i -> tracker pops, no write, hazard on that register clears.
- Assert rst_ni low with two FIFO entries and one load pending -> all outputs 0; no rf_we_o after release; hazards 0.
